// File: rtl/sr04_echo_emulator.sv
// HC-SR04 responder: qualifies trigger, waits burst delay, drives echo.
// Define SR04_EMU_RANGE_CHECK_EN for timeout echo on out-of-range distance.
//
// Ports:
//   clk         system clock
//   reset       synchronous active-low reset
//   trigger     async trigger from controller (2-flop synchronized)
//   distance_cm emulated target distance in cm, latched on valid trigger
//   echo        registered echo pulse
//   busy        high outside IDLE and TRIG_HIGH
//   trig_short  one-clk pulse when a trigger is rejected as too short
module sr04_echo_emulator #(
    parameter int CLK_DIV     = 100,
    parameter int TRIG_MIN_US = 10,
    parameter int BURST_US    = 200,
    parameter int US_PER_CM   = 58,
    parameter int MAX_CM      = 400,
    parameter int TIMEOUT_US  = 38000,
    parameter int HOLDOFF_US  = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       trigger,
    input  logic [8:0] distance_cm,
    output logic       echo,
    output logic       busy,
    output logic       trig_short
);

    localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
    localparam logic [15:0] TRIG_MIN   = 16'(TRIG_MIN_US);
    localparam logic [15:0] BURST_LAST = 16'(BURST_US - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(HOLDOFF_US - 1);
    localparam logic [15:0] TRIG_SAT   = 16'd15;

    typedef enum logic [2:0] {
        IDLE,
        TRIG_HIGH,
        BURST,
        ECHO,
        HOLDOFF
    } state_t;

    state_t      state;
    logic        sync1;
    logic        trig_s;
    logic        trig_prev;
    logic [15:0] div;
    logic [15:0] us_cnt;
    logic [8:0]  latched_cm;
    logic [15:0] product;
    logic [15:0] echo_w;
    logic        skip_echo;
    logic        tick;
    logic        trig_rise;
    logic        trig_fall;

    assign tick      = (div == DIV_LAST);
    assign trig_rise = trig_s & ~trig_prev;
    assign trig_fall = ~trig_s & trig_prev;
    assign product   = 16'(latched_cm) * 16'(US_PER_CM);

`ifdef SR04_EMU_RANGE_CHECK_EN
    logic out_of_range;
    assign out_of_range = (latched_cm == 9'd0) ||
                          (16'(latched_cm) > 16'(MAX_CM));
    assign echo_w    = out_of_range ? 16'(TIMEOUT_US) : product;
    assign skip_echo = 1'b0;
`else
    assign echo_w    = product;
    // A zero-width echo is not emitted at all.
    assign skip_echo = (latched_cm == 9'd0);
    // Range limits are only consumed by the range-check build.
    if (MAX_CM < 0 || TIMEOUT_US < 0) begin : g_range_unused
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            sync1      <= 1'b0;
            trig_s     <= 1'b0;
            trig_prev  <= 1'b0;
            div        <= '0;
            us_cnt     <= '0;
            latched_cm <= '0;
            echo       <= 1'b0;
            busy       <= 1'b0;
            trig_short <= 1'b0;
        end else begin
            sync1      <= trigger;
            trig_s     <= sync1;
            trig_prev  <= trig_s;
            trig_short <= 1'b0;
            // Free-running divider; every state change restarts it.
            div <= tick ? '0 : div + 16'd1;

            unique case (state)
                IDLE: begin
                    if (trig_rise) begin
                        state  <= TRIG_HIGH;
                        div    <= '0;
                        us_cnt <= '0;
                    end
                end
                TRIG_HIGH: begin
                    if (trig_fall) begin
                        div    <= '0;
                        us_cnt <= '0;
                        if (us_cnt >= TRIG_MIN) begin
                            latched_cm <= distance_cm;
                            state      <= BURST;
                            busy       <= 1'b1;
                        end else begin
                            trig_short <= 1'b1;
                            state      <= IDLE;
                        end
                    end else if (tick && us_cnt != TRIG_SAT) begin
                        us_cnt <= us_cnt + 16'd1;
                    end
                end
                BURST: begin
                    if (tick) begin
                        if (us_cnt == BURST_LAST) begin
                            div    <= '0;
                            us_cnt <= '0;
                            if (skip_echo) begin
                                state <= HOLDOFF;
                            end else begin
                                state <= ECHO;
                                echo  <= 1'b1;
                            end
                        end else begin
                            us_cnt <= us_cnt + 16'd1;
                        end
                    end
                end
                ECHO: begin
                    if (tick) begin
                        if (us_cnt == echo_w - 16'd1) begin
                            div    <= '0;
                            us_cnt <= '0;
                            state  <= HOLDOFF;
                            echo   <= 1'b0;
                        end else begin
                            us_cnt <= us_cnt + 16'd1;
                        end
                    end
                end
                HOLDOFF: begin
                    if (tick) begin
                        if (us_cnt == HOLD_LAST) begin
                            div    <= '0;
                            us_cnt <= '0;
                            state  <= IDLE;
                            busy   <= 1'b0;
                        end else begin
                            us_cnt <= us_cnt + 16'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    echo  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr04_echo_emulator.sv
// Self-checking bench for sr04_echo_emulator with scaled-down timing.
// Expected timings come from a plain arithmetic model of the sensor rules.
module tb_sr04_echo_emulator;

    localparam int D   = 3;
    localparam int TM  = 10;
    localparam int B   = 20;
    localparam int UPC = 2;
    localparam int MXC = 400;
    localparam int TO  = 1000;
    localparam int H   = 40;
    localparam int LIM = 20000;

    logic       clk;
    logic       reset;
    logic       trigger;
    logic [8:0] distance_cm;
    logic       echo;
    logic       busy;
    logic       trig_short;

    int passed;
    int total;

    sr04_echo_emulator #(
        .CLK_DIV     (D),
        .TRIG_MIN_US (TM),
        .BURST_US    (B),
        .US_PER_CM   (UPC),
        .MAX_CM      (MXC),
        .TIMEOUT_US  (TO),
        .HOLDOFF_US  (H)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .trigger     (trigger),
        .distance_cm (distance_cm),
        .echo        (echo),
        .busy        (busy),
        .trig_short  (trig_short)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_echo_us(input int cm);
`ifdef SR04_EMU_RANGE_CHECK_EN
        if (cm == 0 || cm > MXC) return TO;
`endif
        return cm * UPC;
    endfunction

    // mode 0: plain, 1: retrigger + distance change, 2: hold trigger high
    task automatic run_meas(input int cm, input int tclks, input int mode);
        int n;
        int w;
        int h;
        int exp_us;
        bit seen;
        exp_us = exp_echo_us(cm);
        distance_cm = 9'(cm);
        trigger = 1'b1;
        repeat (tclks) step();
        trigger = 1'b0;
        repeat (3) step();
        n = 3;
        total++;
        if (busy !== 1'b1)
            $display("FAIL busy_start cm=%0d got=%b exp=1", cm, busy);
        else passed++;
        if (exp_us == 0) begin
            seen = 1'b0;
            while (busy === 1'b1 && n < LIM) begin
                step();
                n++;
                if (echo !== 1'b0) seen = 1'b1;
            end
            total++;
            if (seen)
                $display("FAIL zero_no_echo cm=%0d got=1 exp=0", cm);
            else passed++;
            total++;
            if (n != 3 + (B + H) * D)
                $display("FAIL zero_busy_len got=%0d exp=%0d",
                         n, 3 + (B + H) * D);
            else passed++;
            return;
        end
        while (echo !== 1'b1 && n < LIM) begin
            step();
            n++;
        end
        total++;
        if (n != 3 + B * D)
            $display("FAIL echo_rise cm=%0d got=%0d exp=%0d",
                     cm, n, 3 + B * D);
        else passed++;
        w = 0;
        while (echo === 1'b1 && w < LIM) begin
            step();
            w++;
            if (mode == 1) begin
                if (w == 2) trigger = 1'b1;
                if (w == 2 + 12 * D) trigger = 1'b0;
                if (w == 50) distance_cm = 9'($urandom);
            end
        end
        total++;
        if (w != exp_us * D)
            $display("FAIL echo_width cm=%0d got=%0d exp=%0d",
                     cm, w, exp_us * D);
        else passed++;
        h = 0;
        while (busy === 1'b1 && h < LIM) begin
            step();
            h++;
            if (mode == 1) begin
                if (h == 5) trigger = 1'b1;
                if (h == 5 + 12 * D) trigger = 1'b0;
            end
            if (mode == 2 && h == 10) trigger = 1'b1;
        end
        total++;
        if (h != H * D)
            $display("FAIL holdoff cm=%0d got=%0d exp=%0d",
                     cm, h, H * D);
        else passed++;
    endtask

    task automatic quiet(input string nm, input int cycles);
        int bad;
        bad = 0;
        repeat (cycles) begin
            step();
            if (echo !== 1'b0 || busy !== 1'b0) bad++;
        end
        total++;
        if (bad != 0)
            $display("FAIL %s active_cycles got=%0d exp=0", nm, bad);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        trigger = 1'b0;
        distance_cm = '0;
        repeat (3) step();
        total++;
        if (echo !== 1'b0) $display("FAIL rst_echo got=%b exp=0", echo);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy);
        else passed++;
        total++;
        if (trig_short !== 1'b0)
            $display("FAIL rst_short got=%b exp=0", trig_short);
        else passed++;
        reset = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_basic();
        run_meas(100, 12 * D, 0);
        repeat (3) begin
            run_meas(int'($urandom_range(200, 1)),
                     int'($urandom_range(15 * D, 11 * D)), 0);
        end
    endtask

    task automatic test_short(input int tclks);
        int cnt;
        int pos;
        int bad;
        cnt = 0;
        pos = 0;
        bad = 0;
        trigger = 1'b1;
        repeat (tclks) step();
        trigger = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (trig_short === 1'b1) begin
                cnt++;
                pos = i;
            end
            if (echo !== 1'b0 || busy !== 1'b0) bad++;
        end
        total++;
        if (cnt != 1) $display("FAIL short_count got=%0d exp=1", cnt);
        else passed++;
        total++;
        if (pos != 3) $display("FAIL short_pos got=%0d exp=3", pos);
        else passed++;
        total++;
        if (bad != 0) $display("FAIL short_quiet got=%0d exp=0", bad);
        else passed++;
    endtask

    task automatic test_range();
        run_meas(450, 12 * D, 0);
        run_meas(0, 12 * D, 0);
        run_meas(400, 12 * D, 0);
        run_meas(401, 12 * D, 0);
    endtask

    task automatic test_retrigger();
        run_meas(int'($urandom_range(200, 20)), 12 * D, 1);
        quiet("retrig_after", 30);
    endtask

    task automatic test_trig_held();
        int bad;
        bad = 0;
        run_meas(int'($urandom_range(100, 1)), 12 * D, 2);
        repeat (60) begin
            step();
            if (echo !== 1'b0 || busy !== 1'b0 || trig_short !== 1'b0)
                bad++;
        end
        total++;
        if (bad != 0) $display("FAIL held_ignored got=%0d exp=0", bad);
        else passed++;
        trigger = 1'b0;
        repeat (5) step();
        run_meas(int'($urandom_range(100, 1)), 12 * D, 0);
    endtask

    task automatic test_reset_mid_echo();
        int n;
        distance_cm = 9'd50;
        trigger = 1'b1;
        repeat (12 * D) step();
        trigger = 1'b0;
        n = 0;
        while (echo !== 1'b1 && n < LIM) begin
            step();
            n++;
        end
        total++;
        if (echo !== 1'b1) $display("FAIL rme_rise got=%b exp=1", echo);
        else passed++;
        repeat (10) step();
        reset = 1'b0;
        step();
        total++;
        if (echo !== 1'b0) $display("FAIL rme_echo got=%b exp=0", echo);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL rme_busy got=%b exp=0", busy);
        else passed++;
        reset = 1'b1;
        quiet("rme_after", 20);
        run_meas(int'($urandom_range(150, 1)), 12 * D, 0);
    endtask

    initial begin
        passed = 0;
        total = 0;
        test_reset();
        test_basic();
        test_short(5 * D);
        test_short(int'($urandom_range(9 * D, D)));
        test_range();
        test_retrigger();
        test_trig_held();
        test_reset_mid_echo();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
